msu_data_fetch: RTL and testbench

//  Storage-side responder for the MSU-1 data track port. Turns the MSU front-end's data_seek/data_req/data_addr into

---
 rtl/msu_data_fetch_pkg.sv | 21 ++
 rtl/msu_data_fetch_if.sv | 34 +++
 rtl/msu_data_fetch_ram.sv | 37 +++
 rtl/msu_data_fetch.sv | 192 +++++++++++++++++++
 tb/tb_msu_data_fetch.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/msu_data_fetch_pkg.sv
// Shared definitions for the MSU-1 data track fetch unit.
//  SECTOR_BITS : log2 bytes per SD sector (512-byte sectors)
//  ADDR_W      : width of the byte pointer into the data track
//  LBA_W       : width of a sector number (byte pointer minus in-sector offset)
//  fetch_state_t : sector fetch sequencer states
package msu_data_fetch_pkg;

    localparam int SECTOR_BITS = 9;
    localparam int ADDR_W      = 32;
    localparam int LBA_W       = ADDR_W - SECTOR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_CUR  = 3'd1,
        ST_WAIT_CUR = 3'd2,
        ST_REQ_NXT  = 3'd3,
        ST_WAIT_NXT = 3'd4,
        ST_READY    = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/msu_data_fetch_if.sv
// Bundle of the MSU front-end data port and the HPS SD image channel.
//  slave  : the fetch unit (consumes seek/req/SD bytes, produces data/ack/sd_rd)
//  master : front-end plus SD host side driving the fetch unit
//  data_addr/data_seek/data_req   front-end byte pointer, seek level, advance pulse
//  data/data_ack/underrun         byte out, seek-done pulse, sticky underrun flag
//  sd_lba/sd_rd/sd_ack            sector request handshake
//  sd_buff_addr/dout/wr           incoming sector byte stream
interface msu_data_fetch_if #(
    parameter int SECTOR_BITS = msu_data_fetch_pkg::SECTOR_BITS,
    parameter int ADDR_W      = msu_data_fetch_pkg::ADDR_W
);
    logic [ADDR_W-1:0]             data_addr;
    logic                          data_seek;
    logic                          data_req;
    logic [7:0]                    data;
    logic                          data_ack;
    logic [ADDR_W-SECTOR_BITS-1:0] sd_lba;
    logic                          sd_rd;
    logic                          sd_ack;
    logic [SECTOR_BITS-1:0]        sd_buff_addr;
    logic [7:0]                    sd_buff_dout;
    logic                          sd_buff_wr;
    logic                          underrun;

    modport slave (
        input  data_addr, data_seek, data_req, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output data, data_ack, sd_lba, sd_rd, underrun
    );

    modport master (
        output data_addr, data_seek, data_req, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  data, data_ack, sd_lba, sd_rd, underrun
    );
endinterface

// File: rtl/msu_data_fetch_ram.sv
// Two-bank sector buffer: simple dual-port RAM, synchronous write on port A,
// synchronous (1-cycle) read on port B with a resettable output register.
//  CLK/RESET : clock, async active-high reset (clears read register only)
//  we/waddr/wdata : write port
//  raddr/rdata    : read port, rdata valid one cycle after raddr
module msu_data_fetch_ram #(
    parameter int AW = 10
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem_q [0:(1<<AW)-1];
    logic [7:0] rdata_q;

    // Write port: storage array has no reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: re-read every cycle so bank switches show up without a request.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rdata_q <= 8'd0;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/msu_data_fetch.sv
// MSU-1 data track fetch unit: turns seeks and byte advances from the MSU
// front-end into SD sector reads and serves bytes from a ping-pong buffer.
//  CLK, RESET : single clock, async active-high reset
//  bus        : msu_data_fetch_if slave modport (front-end + SD channel)
module msu_data_fetch
    import msu_data_fetch_pkg::*;
#(
    parameter int SECTOR_BITS = msu_data_fetch_pkg::SECTOR_BITS,
    parameter int ADDR_W      = msu_data_fetch_pkg::ADDR_W
) (
    input  logic             CLK,
    input  logic             RESET,
    msu_data_fetch_if.slave  bus
);
    localparam int LW = ADDR_W - SECTOR_BITS;

    fetch_state_t  state_q, state_d;
    logic [LW-1:0] sd_lba_q, sd_lba_d, pend_lba_q, pend_lba_d, addr_lba_s, start_lba_s;
    logic [1:0]    bank_valid_q, bank_valid_d;
    logic          sd_rd_q, sd_rd_d, data_ack_q, data_ack_d, underrun_q, underrun_d;
    logic          cur_bank_q, cur_bank_d, load_bank_q, load_bank_d;
    logic          seek_pending_q, seek_pending_d, seek_ack_q, seek_ack_d, defer_q, defer_d;
    logic          sd_ack_prev_q, seek_prev_q;
    logic          seek_rise_s, ack_fall_s, cross_s, busy_s, start_s, toggle_s;
    logic [7:0]    rd_data_s;

    assign seek_rise_s = bus.data_seek & ~seek_prev_q;
    assign ack_fall_s  = sd_ack_prev_q & ~bus.sd_ack;
    // data_addr has already advanced, so offset 0 means we just stepped into the next sector.
    assign cross_s     = bus.data_req & (bus.data_addr[SECTOR_BITS-1:0] == '0);
    assign addr_lba_s  = bus.data_addr[ADDR_W-1:SECTOR_BITS];
    assign busy_s      = (state_q == ST_REQ_CUR) || (state_q == ST_WAIT_CUR) ||
                         (state_q == ST_REQ_NXT) || (state_q == ST_WAIT_NXT);

    // Next-state and register updates for the sector fetch sequencer.
    always_comb begin
        state_d        = state_q;
        sd_lba_d       = sd_lba_q;
        pend_lba_d     = pend_lba_q;
        bank_valid_d   = bank_valid_q;
        sd_rd_d        = sd_rd_q;
        data_ack_d     = 1'b0;
        underrun_d     = underrun_q;
        cur_bank_d     = cur_bank_q;
        load_bank_d    = load_bank_q;
        seek_pending_d = seek_pending_q;
        seek_ack_d     = seek_ack_q;
        defer_d        = defer_q;
        start_s        = 1'b0;
        start_lba_s    = addr_lba_s;
        toggle_s       = 1'b0;

        // While a transfer is in flight, seeks are latched and sector crossings deferred.
        if (busy_s) begin
            if (seek_rise_s) begin
                seek_pending_d = 1'b1;
                pend_lba_d     = addr_lba_s;
            end else if (cross_s) begin
                underrun_d = 1'b1;
                defer_d    = 1'b1;
            end else begin
            end
        end else begin
        end

        case (state_q)
            ST_IDLE: begin
                if (seek_rise_s) begin
                    start_s = 1'b1;
                end else begin
                end
            end
            ST_READY: begin
                // Seek wins over a same-cycle data_req.
                if (seek_rise_s) begin
                    start_s = 1'b1;
                end else if (cross_s) begin
                    toggle_s = 1'b1;
                end else begin
                end
            end
            ST_REQ_CUR, ST_REQ_NXT: begin
                if (bus.sd_ack) begin
                    sd_rd_d = 1'b0;
                    state_d = (state_q == ST_REQ_CUR) ? ST_WAIT_CUR : ST_WAIT_NXT;
                end else begin
                end
            end
            ST_WAIT_CUR, ST_WAIT_NXT: begin
                if (ack_fall_s) begin
                    if (seek_pending_q || seek_rise_s) begin
                        // Discard the finished sector and refetch for the newest seek.
                        start_s     = 1'b1;
                        start_lba_s = seek_rise_s ? addr_lba_s : pend_lba_q;
                    end else if (state_q == ST_WAIT_CUR) begin
                        bank_valid_d[load_bank_q] = 1'b1;
                        load_bank_d = ~load_bank_q;
                        sd_lba_d    = sd_lba_q + LW'(1);
                        sd_rd_d     = 1'b1;
                        state_d     = ST_REQ_NXT;
                    end else begin
                        bank_valid_d[load_bank_q] = 1'b1;
                        data_ack_d = seek_ack_q;
                        seek_ack_d = 1'b0;
                        if (defer_q || cross_s) begin
                            toggle_s = 1'b1;
                        end else begin
                            state_d = ST_READY;
                        end
                    end
                end else begin
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_s) begin
            state_d        = ST_REQ_CUR;
            sd_lba_d       = start_lba_s;
            sd_rd_d        = 1'b1;
            cur_bank_d     = 1'b0;
            load_bank_d    = 1'b0;
            bank_valid_d   = 2'b00;
            seek_pending_d = 1'b0;
            seek_ack_d     = 1'b1;
            defer_d        = 1'b0;
        end else if (toggle_s) begin
            // The loaded bank becomes current; the bank just left is refilled with the sector after it.
            cur_bank_d               = ~cur_bank_q;
            load_bank_d              = cur_bank_q;
            bank_valid_d[cur_bank_q] = 1'b0;
            sd_lba_d                 = sd_lba_q + LW'(1);
            sd_rd_d                  = 1'b1;
            defer_d                  = 1'b0;
            state_d                  = ST_REQ_NXT;
        end else begin
        end
    end

    // Sequencer state, handshake outputs and edge-detector history.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            sd_lba_q       <= '0;
            pend_lba_q     <= '0;
            bank_valid_q   <= 2'b00;
            sd_rd_q        <= 1'b0;
            data_ack_q     <= 1'b0;
            underrun_q     <= 1'b0;
            cur_bank_q     <= 1'b0;
            load_bank_q    <= 1'b0;
            seek_pending_q <= 1'b0;
            seek_ack_q     <= 1'b0;
            defer_q        <= 1'b0;
            sd_ack_prev_q  <= 1'b0;
            seek_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sd_lba_q       <= sd_lba_d;
            pend_lba_q     <= pend_lba_d;
            bank_valid_q   <= bank_valid_d;
            sd_rd_q        <= sd_rd_d;
            data_ack_q     <= data_ack_d;
            underrun_q     <= underrun_d;
            cur_bank_q     <= cur_bank_d;
            load_bank_q    <= load_bank_d;
            seek_pending_q <= seek_pending_d;
            seek_ack_q     <= seek_ack_d;
            defer_q        <= defer_d;
            sd_ack_prev_q  <= bus.sd_ack;
            seek_prev_q    <= bus.data_seek;
        end
    end

    msu_data_fetch_ram #(.AW(SECTOR_BITS + 1)) u_ram (
        .CLK   (CLK),
        .RESET (RESET),
        .we    (bus.sd_buff_wr),
        .waddr ({load_bank_q, bus.sd_buff_addr}),
        .wdata (bus.sd_buff_dout),
        .raddr ({cur_bank_q, bus.data_addr[SECTOR_BITS-1:0]}),
        .rdata (rd_data_s)
    );

    assign bus.data     = rd_data_s;
    assign bus.data_ack = data_ack_q;
    assign bus.sd_lba   = sd_lba_q;
    assign bus.sd_rd    = sd_rd_q;
    assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_msu_data_fetch.sv
// Directed bench for msu_data_fetch: an SD host model serves sectors whose
// numbers are checked against a scoreboard queue filled by the stimulus.
module tb_msu_data_fetch;
    import msu_data_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    msu_data_fetch_if bus ();

    msu_data_fetch dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.data_ack === 1'b1) ack_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pat(input int lba, input int idx);
        logic [31:0] v;
        v = idx * 5 + lba * 71 + (idx >> 4);
        return v[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for a sector request, compare its number with the scoreboard, raise sd_ack.
    task automatic sd_start();
        logic [31:0] exp;
        int n;
        exp = 32'hFFFF_FFFF;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        n = 0;
        while (bus.sd_rd !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("sd_rd_seen", {31'd0, bus.sd_rd}, 32'd1);
        chk("sd_lba", {9'd0, bus.sd_lba}, exp);
        bus.sd_ack = 1'b1;
        tick();
        chk("sd_rd_drop", {31'd0, bus.sd_rd}, 32'd0);
    endtask

    task automatic sd_finish(input int lba);
        for (int i = 0; i < 512; i++) begin
            bus.sd_buff_wr   = 1'b1;
            bus.sd_buff_addr = 9'(i);
            bus.sd_buff_dout = pat(lba, i);
            tick();
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = 1'b0;
        tick();
    endtask

    task automatic seek(input logic [31:0] addr);
        bus.data_seek = 1'b0;
        tick();
        bus.data_addr = addr;
        bus.data_seek = 1'b1;
        tick();
    endtask

    task automatic req(input logic [31:0] addr);
        bus.data_addr = addr;
        bus.data_req  = 1'b1;
        tick();
        bus.data_req  = 1'b0;
    endtask

    initial begin
        bus.data_addr    = 32'd0;
        bus.data_seek    = 1'b0;
        bus.data_req     = 1'b0;
        bus.sd_ack       = 1'b0;
        bus.sd_buff_addr = 9'd0;
        bus.sd_buff_dout = 8'd0;
        bus.sd_buff_wr   = 1'b0;
        tick();
        tick();
        chk("rst_data", {24'd0, bus.data}, 32'd0);
        chk("rst_ack", {31'd0, bus.data_ack}, 32'd0);
        chk("rst_sd_rd", {31'd0, bus.sd_rd}, 32'd0);
        chk("rst_lba", {9'd0, bus.sd_lba}, 32'd0);
        chk("rst_underrun", {31'd0, bus.underrun}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: seek 0x203 -> sectors 1 then 2, one ack after the second.
        seek(32'h203);
        sb_q.push_back(32'd1);
        sb_q.push_back(32'd2);
        sd_start();
        sd_finish(1);
        chk("t1_no_early_ack", ack_cnt, 0);
        sd_start();
        sd_finish(2);
        chk("t1_ack_high", {31'd0, bus.data_ack}, 32'd1);
        tick();
        chk("t1_ack_pulse", {31'd0, bus.data_ack}, 32'd0);
        chk("t1_ack_cnt", ack_cnt, 1);
        chk("t1_data", {24'd0, bus.data}, {24'd0, pat(1, 3)});

        // 2: stream across the sector boundary into bank 1, prefetch sector 3.
        req(32'h3FE);
        chk("t2_d1fe", {24'd0, bus.data}, {24'd0, pat(1, 32'h1FE)});
        req(32'h3FF);
        chk("t2_d1ff", {24'd0, bus.data}, {24'd0, pat(1, 32'h1FF)});
        sb_q.push_back(32'd3);
        req(32'h400);
        tick();
        chk("t2_d000", {24'd0, bus.data}, {24'd0, pat(2, 0)});
        req(32'h401);
        chk("t2_d001", {24'd0, bus.data}, {24'd0, pat(2, 1)});
        chk("t2_underrun", {31'd0, bus.underrun}, 32'd0);

        // 4: cross again while sector 3 is still loading.
        sd_start();
        req(32'h5FF);
        chk("t4_d1ff", {24'd0, bus.data}, {24'd0, pat(2, 32'h1FF)});
        req(32'h600);
        chk("t4_underrun", {31'd0, bus.underrun}, 32'd1);
        sb_q.push_back(32'd4);
        sd_finish(3);
        tick();
        chk("t4_data", {24'd0, bus.data}, {24'd0, pat(3, 0)});
        sd_start();
        sd_finish(4);
        tick();
        chk("t4_no_ack", ack_cnt, 1);

        // 3: seek during WAIT_NXT; the in-flight load is discarded.
        seek(32'hC05);
        sb_q.push_back(32'd6);
        sb_q.push_back(32'd7);
        sd_start();
        sd_finish(6);
        sd_start();
        seek(32'h1000);
        sb_q.push_back(32'd8);
        sb_q.push_back(32'd9);
        sd_finish(7);
        chk("t3_no_abort_ack", ack_cnt, 1);
        sd_start();
        sd_finish(8);
        sd_start();
        sd_finish(9);
        tick();
        chk("t3_ack_cnt", ack_cnt, 2);
        chk("t3_data", {24'd0, bus.data}, {24'd0, pat(8, 0)});

        // 5: seek rise and data_req in the same cycle at a sector-aligned address.
        bus.data_seek = 1'b0;
        tick();
        bus.data_addr = 32'h1400;
        bus.data_seek = 1'b1;
        bus.data_req  = 1'b1;
        tick();
        bus.data_req  = 1'b0;
        sb_q.push_back(32'd10);
        sb_q.push_back(32'd11);
        sd_start();
        sd_finish(10);
        sd_start();
        sd_finish(11);
        tick();
        chk("t5_ack_cnt", ack_cnt, 3);
        chk("t5_data", {24'd0, bus.data}, {24'd0, pat(10, 0)});

        // 6: reset in the middle of the first sector load.
        seek(32'h2000);
        sb_q.push_back(32'd16);
        sd_start();
        for (int i = 0; i < 10; i++) begin
            bus.sd_buff_wr   = 1'b1;
            bus.sd_buff_addr = 9'(i);
            bus.sd_buff_dout = pat(16, i);
            tick();
        end
        rst = 1'b1;
        bus.data_seek = 1'b0;
        #1;
        chk("t6_data", {24'd0, bus.data}, 32'd0);
        chk("t6_ack", {31'd0, bus.data_ack}, 32'd0);
        chk("t6_sd_rd", {31'd0, bus.sd_rd}, 32'd0);
        chk("t6_lba", {9'd0, bus.sd_lba}, 32'd0);
        chk("t6_underrun", {31'd0, bus.underrun}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 10; i < 512; i++) begin
            bus.sd_buff_wr   = 1'b1;
            bus.sd_buff_addr = 9'(i);
            bus.sd_buff_dout = pat(16, i);
            tick();
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = 1'b0;
        tick();
        tick();
        chk("t6_idle_sd_rd", {31'd0, bus.sd_rd}, 32'd0);
        chk("t6_no_ack", ack_cnt, 3);
        seek(32'h0);
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd1);
        sd_start();
        sd_finish(0);
        sd_start();
        sd_finish(1);
        tick();
        chk("t6_ack_cnt", ack_cnt, 4);
        chk("t6_data_after", {24'd0, bus.data}, {24'd0, pat(0, 0)});
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
